// File: rtl/pbi_dma_sequencer.sv
// pbi_dma_sequencer
// Moves bytes between Atari RAM on the PBI bus and the W5300 16-bit FIFO.
// Each byte uses one halted Phi2 cycle. The block handles the DMA
// request/halt handshake, the address and count counters, and a pad access
// that completes the 16-bit FIFO word when the count is odd. It also times
// the FIFO read/write strobes within each Phi2 cycle.
// The PBI register decoder loads the block through the Cfg* strobe interface.
//
// Ports:
//   CLK1      16x Phi2 clock
//   Reset     synchronous, active-high
//   Phi2      system Phi2, already synchronous to CLK1
//   Halt      active-low bus grant (0 = CPU halted)
//   CfgWr     one-cycle write strobe; CfgSel selects the register; CfgData is the data
//             (0 AddrLo, 1 AddrHi, 2 CountLo, 3 CountHi, 4 Start with bit0 = Dir, 5 Abort)
//   DmaReq    request to the external open-drain driver
//   BusAddrEn drive BusAddr onto SysAddr
//   BusAddr   current DMA address
//   BusRdWr   RdWr to drive (0 = write RAM, 1 = read RAM)
//   DevRd     W5300 FIFO read strobe
//   DevWr     W5300 FIFO write strobe
//   Busy      transfer in progress
//   Done      sticky completion flag
module pbi_dma_sequencer #(
  parameter int RD_START = 2,
  parameter int RD_LEN   = 3,
  parameter int WR_START = 12,
  parameter int WR_LEN   = 2
) (
  input  logic        CLK1,
  input  logic        Reset,
  input  logic        Phi2,
  input  logic        Halt,
  input  logic        CfgWr,
  input  logic [2:0]  CfgSel,
  input  logic [7:0]  CfgData,
  output logic        DmaReq,
  output logic        BusAddrEn,
  output logic [15:0] BusAddr,
  output logic        BusRdWr,
  output logic        DevRd,
  output logic        DevWr,
  output logic        Busy,
  output logic        Done
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_XFER = 3'd2;
  localparam logic [2:0] ST_PAD  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [2:0] SEL_ADDR_LO  = 3'd0;
  localparam logic [2:0] SEL_ADDR_HI  = 3'd1;
  localparam logic [2:0] SEL_COUNT_LO = 3'd2;
  localparam logic [2:0] SEL_COUNT_HI = 3'd3;
  localparam logic [2:0] SEL_START    = 3'd4;
  localparam logic [2:0] SEL_ABORT    = 3'd5;

  // Strobe windows, in phases of the current bus cycle. They must end at or
  // before phase 15.
  localparam logic [3:0] RD_FIRST = 4'(RD_START);
  localparam logic [3:0] RD_LAST  = 4'(RD_START + RD_LEN - 1);
  localparam logic [3:0] WR_FIRST = 4'(WR_START);
  localparam logic [3:0] WR_LAST  = 4'(WR_START + WR_LEN - 1);

  logic [2:0]  state_reg;
  logic        phi2_d_reg;
  logic [3:0]  phase_reg;
  logic [15:0] addr_reg;
  logic [15:0] count_reg;
  logic        dir_reg;
  logic        odd_reg;
  logic        dma_req_reg;
  logic        done_reg;
  logic        pad_go_reg;     // PAD has been granted and is running its access
  logic        abort_pend_reg; // abort waiting for the current bus cycle to end

  logic        phi2_fall;
  logic        bus_cycle;
  logic        abort_req;
  logic        abort_now;
  logic [15:0] addr_inc;
  logic [15:0] count_dec;

  assign phi2_fall = phi2_d_reg & ~Phi2;
  assign bus_cycle = (state_reg == ST_XFER) || ((state_reg == ST_PAD) && pad_go_reg);
  assign abort_req = abort_pend_reg || (CfgWr && (CfgSel == SEL_ABORT));
  // An abort during a bus cycle waits for the cycle to finish at the next Phi2 fall.
  // In any other non-idle state it takes effect at once.
  assign abort_now = (state_reg != ST_IDLE) && abort_req && (phi2_fall || !bus_cycle);
  assign addr_inc  = addr_reg + 16'd1;
  assign count_dec = count_reg - 16'd1;

  always_ff @(posedge CLK1) begin
    if (Reset) begin
      state_reg      <= ST_IDLE;
      phi2_d_reg     <= 1'b0;
      phase_reg      <= 4'd0;
      addr_reg       <= 16'd0;
      count_reg      <= 16'd0;
      dir_reg        <= 1'b0;
      odd_reg        <= 1'b0;
      dma_req_reg    <= 1'b0;
      done_reg       <= 1'b0;
      pad_go_reg     <= 1'b0;
      abort_pend_reg <= 1'b0;
    end else begin
      phi2_d_reg <= Phi2;
      // Phase 0 is the first CLK1 cycle after the fall was seen.
      if (phi2_fall) begin
        phase_reg <= 4'd0;
      end else if (phase_reg != 4'd15) begin
        phase_reg <= phase_reg + 4'd1;
      end

      abort_pend_reg <= (state_reg != ST_IDLE) && abort_req && !abort_now;

      if (abort_now) begin
        state_reg   <= ST_IDLE;
        dma_req_reg <= 1'b0;
        done_reg    <= 1'b0;
        pad_go_reg  <= 1'b0;
        // The byte in flight has finished, so count it.
        if (state_reg == ST_XFER) begin
          addr_reg  <= addr_inc;
          count_reg <= count_dec;
        end
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (CfgWr) begin
              case (CfgSel)
                SEL_ADDR_LO:  addr_reg[7:0]   <= CfgData;
                SEL_ADDR_HI:  addr_reg[15:8]  <= CfgData;
                SEL_COUNT_LO: count_reg[7:0]  <= CfgData;
                SEL_COUNT_HI: count_reg[15:8] <= CfgData;
                SEL_START: begin
                  if (count_reg == 16'd0) begin
                    state_reg <= ST_DONE;
                    done_reg  <= 1'b1;
                  end else begin
                    dir_reg     <= CfgData[0];
                    odd_reg     <= count_reg[0];
                    done_reg    <= 1'b0;
                    dma_req_reg <= 1'b1;
                    state_reg   <= ST_REQ;
                  end
                end
                default: ;
              endcase
            end
          end
          ST_REQ: begin
            if (phi2_fall && !Halt) begin
              state_reg <= ST_XFER;
              // Release the CPU after the final access.
              if ((count_reg == 16'd1) && !odd_reg) dma_req_reg <= 1'b0;
            end
          end
          ST_XFER: begin
            if (phi2_fall) begin
              addr_reg  <= addr_inc;
              count_reg <= count_dec;
              if (count_dec != 16'd0) begin
                if (!Halt) begin
                  if ((count_dec == 16'd1) && !odd_reg) dma_req_reg <= 1'b0;
                end else begin
                  state_reg <= ST_REQ;
                end
              end else if (odd_reg) begin
                state_reg  <= ST_PAD;
                pad_go_reg <= !Halt;
                if (!Halt) dma_req_reg <= 1'b0;
              end else begin
                state_reg   <= ST_DONE;
                done_reg    <= 1'b1;
                dma_req_reg <= 1'b0;
              end
            end
          end
          ST_PAD: begin
            if (phi2_fall) begin
              if (pad_go_reg) begin
                state_reg  <= ST_DONE;
                done_reg   <= 1'b1;
                pad_go_reg <= 1'b0;
              end else if (!Halt) begin
                pad_go_reg  <= 1'b1;
                dma_req_reg <= 1'b0;
              end
            end
          end
          ST_DONE: state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign DmaReq    = dma_req_reg;
  assign BusAddrEn = (state_reg == ST_XFER);
  assign BusAddr   = addr_reg;
  assign BusRdWr   = !((state_reg == ST_XFER) && dir_reg);
  assign DevRd     = bus_cycle && !phi2_fall && dir_reg &&
                     (phase_reg >= RD_FIRST) && (phase_reg <= RD_LAST);
  assign DevWr     = bus_cycle && !phi2_fall && !dir_reg &&
                     (phase_reg >= WR_FIRST) && (phase_reg <= WR_LAST);
  assign Busy      = (state_reg == ST_REQ) || (state_reg == ST_XFER) || (state_reg == ST_PAD);
  assign Done      = done_reg;

endmodule

// File: tb/tb_pbi_dma_sequencer.sv
// Testbench for pbi_dma_sequencer.
// A table of transfers runs in a loop. Hand-written sequences cover the
// count-0 start, halt stretching, abort and reset during a transfer.
// A monitor logs each FIFO access and checks the strobe phases.
module tb_pbi_dma_sequencer;
  logic        CLK1 = 1'b0;
  logic        Reset = 1'b1;
  logic        Phi2 = 1'b1;
  logic        Halt = 1'b0;
  logic        CfgWr = 1'b0;
  logic [2:0]  CfgSel = 3'd0;
  logic [7:0]  CfgData = 8'd0;
  logic        DmaReq, BusAddrEn, BusRdWr, DevRd, DevWr, Busy, Done;
  logic [15:0] BusAddr;

  int checks = 0;
  int errors = 0;

  pbi_dma_sequencer dut (
    .CLK1(CLK1), .Reset(Reset), .Phi2(Phi2), .Halt(Halt), .CfgWr(CfgWr),
    .CfgSel(CfgSel), .CfgData(CfgData), .DmaReq(DmaReq), .BusAddrEn(BusAddrEn),
    .BusAddr(BusAddr), .BusRdWr(BusRdWr), .DevRd(DevRd), .DevWr(DevWr),
    .Busy(Busy), .Done(Done)
  );

  always #5 CLK1 = ~CLK1;

  // Phi2 is high for counts 0-7 and low for counts 8-15. The fall is seen in
  // the count-8 cycle, so DUT phase = (phi_cnt - 9) mod 16.
  logic [3:0] phi_cnt = 4'd0;
  always @(posedge CLK1) begin
    #1;
    phi_cnt = phi_cnt + 4'd1;
    Phi2 = ~phi_cnt[3];
  end

  typedef struct {
    logic        en;
    logic [15:0] addr;
    logic        req;
    logic        rdwr;
  } acc_t;
  acc_t acc_q[$];
  int strobe_samples = 0;

  always @(negedge CLK1) begin
    logic [3:0] ph;
    ph = phi_cnt + 4'd7;
    if (DevWr || DevRd) begin
      strobe_samples++;
      checks++;
      if ((DevWr && DevRd) || (DevWr && (ph < 4'd12 || ph > 4'd13)) ||
          (DevRd && (ph < 4'd2 || ph > 4'd4))) begin
        errors++;
        $display("FAIL strobe_window actual phase=%0d rd=%0b wr=%0b required rd in 2-4 or wr in 12-13",
                 ph, DevRd, DevWr);
      end
      if ((DevWr && ph == 4'd12) || (DevRd && ph == 4'd2))
        acc_q.push_back('{BusAddrEn, BusAddr, DmaReq, BusRdWr});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [7:0] data);
    @(posedge CLK1);
    #1;
    CfgWr = 1'b1;
    CfgSel = sel;
    CfgData = data;
    @(posedge CLK1);
    #1;
    CfgWr = 1'b0;
  endtask

  task automatic start_transfer(input logic load, input logic [15:0] addr,
                                input logic [15:0] count, input logic dir);
    if (load) begin
      cfg_write(3'd0, addr[7:0]);
      cfg_write(3'd1, addr[15:8]);
      cfg_write(3'd2, count[7:0]);
      cfg_write(3'd3, count[15:8]);
    end
    acc_q.delete();
    strobe_samples = 0;
    cfg_write(3'd4, {7'd0, dir});
    @(negedge CLK1);
    check("start_busy", 32'(Busy), 32'd1);
    check("start_done_clr", 32'(Done), 32'd0);
    check("start_req", 32'(DmaReq), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (Done !== 1'b1 && n < 3000) begin
      @(negedge CLK1);
      n++;
    end
    check({name, "_done_timeout"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_addr_en(input string name);
    int n;
    n = 0;
    while (BusAddrEn !== 1'b1 && n < 200) begin
      @(negedge CLK1);
      n++;
    end
    check({name, "_addr_en_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic verify(input string name, input logic [15:0] base, input int n_xfer,
                        input int pad, input logic dir, input logic [15:0] final_addr);
    int n;
    n = n_xfer + pad;
    repeat (2) @(negedge CLK1);
    check({name, "_accesses"}, 32'(acc_q.size()), 32'(n));
    for (int i = 0; i < acc_q.size() && i < n; i++) begin
      logic [15:0] ea;
      ea = base + 16'(i);
      check($sformatf("%s_en%0d", name, i), 32'(acc_q[i].en), 32'(i < n_xfer));
      if (i < n_xfer) begin
        check($sformatf("%s_addr%0d", name, i), 32'(acc_q[i].addr), 32'(ea));
        check($sformatf("%s_rdwr%0d", name, i), 32'(acc_q[i].rdwr), 32'(!dir));
      end
      check($sformatf("%s_req%0d", name, i), 32'(acc_q[i].req), 32'(i != n - 1));
    end
    check({name, "_strobe_len"}, 32'(strobe_samples), 32'(n * (dir ? 3 : 2)));
    check({name, "_final_addr"}, 32'(BusAddr), 32'(final_addr));
    check({name, "_busy"}, 32'(Busy), 32'd0);
    check({name, "_done"}, 32'(Done), 32'd1);
    check({name, "_req_off"}, 32'(DmaReq), 32'd0);
    check({name, "_addr_en_off"}, 32'(BusAddrEn), 32'd0);
    $display("xfer %s base=%h accesses=%0d dir=%0b final=%h", name, base, acc_q.size(), dir, BusAddr);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] count;
    logic        dir;
    int          n_xfer;
    int          pad;
    logic [15:0] final_addr;
  } vec_t;
  vec_t vecs[4];

  initial begin
    logic seen;
    int n;
    vecs[0] = '{16'h0600, 16'd3, 1'b0, 3, 1, 16'h0603};
    vecs[1] = '{16'h1234, 16'd2, 1'b1, 2, 0, 16'h1236};
    vecs[2] = '{16'h00FE, 16'd1, 1'b1, 1, 1, 16'h00FF};
    vecs[3] = '{16'h8000, 16'd4, 1'b0, 4, 0, 16'h8004};

    // Reset state
    repeat (4) @(posedge CLK1);
    #1 Reset = 1'b0;
    @(negedge CLK1);
    check("rst_req", 32'(DmaReq), 32'd0);
    check("rst_addr_en", 32'(BusAddrEn), 32'd0);
    check("rst_addr", 32'(BusAddr), 32'd0);
    check("rst_rdwr", 32'(BusRdWr), 32'd1);
    check("rst_strobes", 32'({DevRd, DevWr}), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    $display("reset state checked");

    // Start with Count=0 (count is 0 after reset)
    cfg_write(3'd4, 8'd0);
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK1);
      if (Done === 1'b1) seen = 1'b1;
      check("count0_req", 32'(DmaReq), 32'd0);
    end
    check("count0_done", 32'(seen), 32'd1);
    check("count0_busy", 32'(Busy), 32'd0);
    $display("count0 start done=%0b", Done);

    // Table of plain transfers, bus granted at once
    for (int v = 0; v < 4; v++) begin
      start_transfer(1'b1, vecs[v].addr, vecs[v].count, vecs[v].dir);
      wait_done($sformatf("vec%0d", v));
      verify($sformatf("vec%0d", v), vecs[v].addr, vecs[v].n_xfer, vecs[v].pad,
             vecs[v].dir, vecs[v].final_addr);
    end

    // Halt withdrawn for the second byte; the address wraps FFFF -> 0000
    start_transfer(1'b1, 16'hFFFF, 16'd2, 1'b0);
    wait_addr_en("halt");
    Halt = 1'b1;
    repeat (40) @(negedge CLK1);
    check("halt_addr_en", 32'(BusAddrEn), 32'd0);
    check("halt_req_held", 32'(DmaReq), 32'd1);
    check("halt_busy", 32'(Busy), 32'd1);
    check("halt_wrap_addr", 32'(BusAddr), 32'h0000);
    check("halt_one_access", 32'(acc_q.size()), 32'd1);
    Halt = 1'b0;
    wait_done("halt");
    verify("halt", 16'hFFFF, 2, 0, 1'b0, 16'h0001);

    // Abort during the first of 4 bytes
    start_transfer(1'b1, 16'h2000, 16'd4, 1'b1);
    wait_addr_en("abort");
    cfg_write(3'd5, 8'd0);
    @(negedge CLK1);
    check("abort_deferred", 32'(BusAddrEn), 32'd1);
    n = 0;
    while (Busy !== 1'b0 && n < 100) begin
      @(negedge CLK1);
      n++;
    end
    check("abort_timeout", 32'(n < 100), 32'd1);
    check("abort_req", 32'(DmaReq), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_addr", 32'(BusAddr), 32'h2001);
    check("abort_addr_en", 32'(BusAddrEn), 32'd0);
    check("abort_accesses", 32'(acc_q.size()), 32'd1);
    $display("abort busy=%0b addr=%h", Busy, BusAddr);
    // Restart without reloading: the remaining count of 3 gives 3 bytes plus a pad
    start_transfer(1'b0, 16'h0000, 16'd0, 1'b1);
    wait_done("abort_resume");
    verify("abort_resume", 16'h2001, 3, 1, 1'b1, 16'h2004);

    // Reset in the middle of a read strobe
    start_transfer(1'b1, 16'h3000, 16'd2, 1'b1);
    n = 0;
    while (DevRd !== 1'b1 && n < 200) begin
      @(negedge CLK1);
      n++;
    end
    check("midrst_devrd_timeout", 32'(n < 200), 32'd1);
    Reset = 1'b1;
    @(negedge CLK1);
    check("midrst_req", 32'(DmaReq), 32'd0);
    check("midrst_addr_en", 32'(BusAddrEn), 32'd0);
    check("midrst_strobes", 32'({DevRd, DevWr}), 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_rdwr", 32'(BusRdWr), 32'd1);
    Reset = 1'b0;
    $display("reset mid-transfer busy=%0b", Busy);
    start_transfer(1'b1, 16'h4000, 16'd2, 1'b0);
    wait_done("post_rst");
    verify("post_rst", 16'h4000, 2, 0, 1'b0, 16'h4002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pbi_dma_sequencer.md
Name: pbi_dma_sequencer

Overview:
Sequences byte-wide DMA transfers between Atari RAM on the PBI bus and the W5300 16-bit FIFO, one byte per halted Phi2 cycle. It owns DMA request/halt handshaking, the address and count counters, byte pairing with a pad access on odd counts, and the device read/write strobe timing within the Phi2 cycle. It sits beside the PBI register decoder, which loads it through a simple strobe interface. It runs on the 16x-Phi2 clock.

Parameters:
RD_START, 2, CLK1 phase (after Phi2 fall) at which DevRd asserts
RD_LEN, 3, DevRd width in CLK1 cycles
WR_START, 12, CLK1 phase at which DevWr asserts
WR_LEN, 2, DevWr width in CLK1 cycles

Ports:
CLK1  in  1  28 MHz clock (16x Phi2)
Reset  in  1  synchronous, active-high
Phi2  in  1  system Phi2, already synchronous to CLK1
Halt  in  1  active-low; 0 = CPU halted, bus granted
CfgWr  in  1  one-cycle register write strobe
CfgSel  in  3  0=AddrLo, 1=AddrHi, 2=CountLo, 3=CountHi, 4=Start, 5=Abort
CfgData  in  8  write data; Start uses bit0 as Dir (1 = device->RAM)
DmaReq  out  1  request to the external open-drain driver
BusAddrEn  out  1  drive BusAddr onto SysAddr
BusAddr  out  16  current DMA address
BusRdWr  out  1  RdWr to drive: 0 = write RAM (Dir=1), 1 = read RAM
DevRd  out  1  W5300 FIFO read strobe
DevWr  out  1  W5300 FIFO write strobe
Busy  out  1  transfer in progress
Done  out  1  sticky completion flag; cleared by Start or Reset

Behaviour:
- Reset: all outputs 0, BusRdWr=1, state IDLE, address/count/phase = 0.
- Phi2Fall = Phi2 high in the previous CLK1 cycle and low now. Phase counter clears to 0 on Phi2Fall and increments each CLK1 cycle, saturating at 15.
- Addr and Count registers are writable only in IDLE. Writes outside IDLE are ignored.
- States: IDLE, REQ, XFER, PAD, DONE.
- IDLE + Start:
  - Count==0: go directly to DONE, no bus cycles.
  - Otherwise: latch Dir, set Odd=Count[0], Done<=0, go to REQ. DmaReq=1 and Busy=1 from the next cycle.
- REQ: on Phi2Fall with Halt==0, go to XFER and start a bus cycle. With Halt==1, stay in REQ.
- XFER bus cycle, Phi2Fall to Phi2Fall:
  - BusAddrEn=1 for the whole cycle.
  - BusRdWr = !Dir.
  - Dir=1: DevRd asserts for phases RD_START..RD_START+RD_LEN-1.
  - Dir=0: DevWr asserts for phases WR_START..WR_START+WR_LEN-1.
- At the Phi2Fall that ends an XFER cycle: Addr<=Addr+1 (wraps FFFF->0000) and Count<=Count-1. Then:
  - New Count!=0 and Halt==0: start the next XFER cycle at this same edge.
  - New Count!=0 and Halt==1: return to REQ.
  - New Count==0 and Odd: go to PAD.
  - New Count==0 and not Odd: go to DONE.
- DmaReq deasserts at the Phi2Fall that starts the final bus access (the last XFER if not Odd, otherwise PAD), so the CPU is released after that cycle.
- PAD: one Phi2 cycle with BusAddrEn=0 and the same DevRd/DevWr strobe pattern (dummy FIFO access to complete the 16-bit word). If Halt==1 at the Phi2Fall entering PAD, wait with DmaReq still asserted. Exit to DONE at the following Phi2Fall.
- DONE: Done=1, Busy=0, DmaReq=0, then IDLE on the next cycle. Done stays set.
- Abort in any non-IDLE state:
  - Takes effect at the next Phi2Fall, or immediately if no bus cycle is in progress.
  - Drops DmaReq, BusAddrEn and strobes; goes to IDLE with Done=0.
  - Count and Addr hold their current values.
- Start while Busy is ignored.
- Reset mid-transfer: all outputs drop in the next cycle.
- Strobes never overlap a Phi2Fall. A strobe window must not extend past phase 15.

Test Plan:
- Addr=0x0600, Count=3, Start Dir=0, Halt grant on the first Phi2Fall -> 3 XFER cycles at 0600/0601/0602 with BusRdWr=1 and a DevWr pulse (phases 12-13) each, then 1 PAD cycle with DevWr and BusAddrEn=0; DmaReq drops at the PAD-start edge; Done=1; Count=0, Addr=0x0603.
- Count=2, Dir=1 -> 2 cycles with BusRdWr=0 and DevRd at phases 2-4, no PAD, Done=1 after the second cycle.
- Count=0, Start -> Done=1 within 2 CLK1, DmaReq never asserts.
- Addr=0xFFFF, Count=2, Halt held 1 for the second cycle -> cycle at FFFF, back to REQ, resume at 0x0000 once Halt=0, Done=1.
- Abort after 1 of 4 bytes -> DmaReq=0 at the next Phi2Fall, Count=3, Addr=base+1, Done=0, Busy=0.
- Reset asserted mid-XFER -> next CLK1: DmaReq, BusAddrEn, DevRd, DevWr, Busy = 0 and BusRdWr=1; a subsequent Start works normally.
